gtx_tx_framer: RTL and testbench

Parametrised GTX transmit framer between the SATA link layer's AXI-Stream TX output and the transceiver's `TXDATA`/`TXCHARISK` inputs. Registers accepted beats onto the transceiver with a per-lane K-character mask, and fills empty cycles with a configurable idle primitive (SYNC by default). Inserts an ALIGN primitive pair on link-up and every `ALIGN_PERIOD` words, back-pressuring the source while it does so. Lane 0 (bits [7:0]) is transmitted first.

---
 rtl/gtx_tx_framer.sv | 175 +++++++++++++++++
 tb/tb_gtx_tx_framer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gtx_tx_framer.sv
// gtx_tx_framer
//
// Transmit framer between the SATA link layer AXI-Stream TX output and a GTX
// transceiver's TXDATA/TXCHARISK inputs.
//
// The link must be up for the framer to start sending. It then sends an ALIGN
// primitive pair, followed by RUN words, followed by another ALIGN pair. Each
// RUN word is either an accepted source beat or the idle primitive. Lane 0
// (bits [7:0]) is transmitted first.
//
// Parameters
//   LANES        bytes per word (2, 4 or 8); DW = 8*LANES
//   ALIGN_PERIOD RUN words between ALIGN pairs (>= 4)
//   ALIGN_WORD   ALIGN primitive (override when LANES != 4)
//   ALIGN_K      K mask sent with ALIGN_WORD
//   IDLE_WORD    idle-fill primitive (SYNC by default)
//   IDLE_K       K mask sent with IDLE_WORD
//
// Ports
//   clk              TXUSRCLK2
//   rst              synchronous active-high reset
//   gtx_ready        transceiver TX reset done, link usable
//   s_axi_tvalid/tready/tdata/tuser/tlast
//                    source beat; tuser is the per-lane K flag
//   gt_txdata_in     registered TXDATA
//   gt_txcharisk_in  registered TXCHARISK
//   align_busy       high while an ALIGN word is on the output
//   frame_done       one-cycle pulse alongside the output word of a tlast beat
//
// Build option
//   GTX_TX_AUTO_K_EN  when defined, any data lane equal to 8'hBC is also
//                     flagged as a K character. When undefined, only
//                     s_axi_tuser drives the beat K mask.

module gtx_tx_framer #(
  parameter int unsigned        LANES        = 4,
  parameter int unsigned        ALIGN_PERIOD = 256,
  parameter logic [8*LANES-1:0] ALIGN_WORD   = 32'h7B4A4ABC,
  parameter logic [LANES-1:0]   ALIGN_K      = 4'b0001,
  parameter logic [8*LANES-1:0] IDLE_WORD    = 32'hB5B5957C,
  parameter logic [LANES-1:0]   IDLE_K       = 4'b0001
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 gtx_ready,
  input  logic                 s_axi_tvalid,
  output logic                 s_axi_tready,
  input  logic [8*LANES-1:0]   s_axi_tdata,
  input  logic [LANES-1:0]     s_axi_tuser,
  input  logic                 s_axi_tlast,
  output logic [8*LANES-1:0]   gt_txdata_in,
  output logic [LANES-1:0]     gt_txcharisk_in,
  output logic                 align_busy,
  output logic                 frame_done
);

  localparam int unsigned DW   = 8 * LANES;
  localparam int unsigned CntW = (ALIGN_PERIOD > 1) ? $clog2(ALIGN_PERIOD) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ALIGN_PERIOD - 1);

  typedef enum logic [1:0] {
    StOff,
    StAlign0,
    StAlign1,
    StRun
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   txdata_q, txdata_d;
  logic [LANES-1:0] txk_q, txk_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [LANES-1:0] beat_k;
  logic             beat_acc;

  // K mask for the incoming beat.
  always_comb begin
    beat_k = s_axi_tuser;
`ifdef GTX_TX_AUTO_K_EN
    for (int unsigned i = 0; i < LANES; i++) begin
      if (s_axi_tdata[8*i +: 8] == 8'hBC) begin
        beat_k[i] = 1'b1;
      end
    end
`endif
  end

  // Ready only in RUN with the link up. The rst term keeps a beat from being
  // handshaken on the edge that discards it.
  assign s_axi_tready = (state_q == StRun) & gtx_ready & ~rst;
  assign beat_acc     = s_axi_tvalid & s_axi_tready;

  // Next state and next output word. Output registers default to zero, which
  // is also what OFF and a link drop put on the wire.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    txdata_d = '0;
    txk_d    = '0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    if (!gtx_ready) begin
      // Link lost: abandon any ALIGN pair; recovery always restarts at ALIGN0.
      state_d = StOff;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StOff: begin
          state_d = StAlign0;
        end
        StAlign0: begin
          state_d  = StAlign1;
          txdata_d = ALIGN_WORD;
          txk_d    = ALIGN_K;
          busy_d   = 1'b1;
        end
        StAlign1: begin
          state_d  = StRun;
          txdata_d = ALIGN_WORD;
          txk_d    = ALIGN_K;
          busy_d   = 1'b1;
        end
        StRun: begin
          if (beat_acc) begin
            txdata_d = s_axi_tdata;
            txk_d    = beat_k;
            done_d   = s_axi_tlast;
          end else begin
            txdata_d = IDLE_WORD;
            txk_d    = IDLE_K;
          end
          // Every RUN cycle counts, idle or data. The beat on the last count
          // is still taken; the ALIGN pair follows it regardless of framing.
          if (cnt_q == CntLast) begin
            state_d = StAlign0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StOff;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StOff;
      cnt_q    <= '0;
      txdata_q <= '0;
      txk_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      txdata_q <= txdata_d;
      txk_q    <= txk_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign gt_txdata_in    = txdata_q;
  assign gt_txcharisk_in = txk_q;
  assign align_busy      = busy_q;
  assign frame_done      = done_q;

endmodule

// File: tb/tb_gtx_tx_framer.sv
// Testbench for gtx_tx_framer. Two instances share control stimulus: a 4-lane
// one and a 2-lane one, both with ALIGN_PERIOD = 8. The 2-lane instance sees
// the low 16 bits of data and the low 2 tuser bits.

module tb_gtx_tx_framer;

  localparam int unsigned Period = 8;
  localparam int KZero  = 0;
  localparam int KAlign = 1;
  localparam int KIdle  = 2;
  localparam int KData  = 3;

`ifdef GTX_TX_AUTO_K_EN
  localparam bit AutoK = 1'b1;
`else
  localparam bit AutoK = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        gtx_ready;
  logic        tvalid;
  logic [31:0] tdata;
  logic [3:0]  tuser;
  logic        tlast;

  logic        a_tready, a_busy, a_done;
  logic [31:0] a_data;
  logic [3:0]  a_k;
  logic        b_tready, b_busy, b_done;
  logic [15:0] b_data;
  logic [1:0]  b_k;

  int n_cmp = 0;
  int n_bad = 0;

  gtx_tx_framer #(
    .LANES       (4),
    .ALIGN_PERIOD(Period)
  ) u_dut_a (
    .clk            (clk),
    .rst            (rst),
    .gtx_ready      (gtx_ready),
    .s_axi_tvalid   (tvalid),
    .s_axi_tready   (a_tready),
    .s_axi_tdata    (tdata),
    .s_axi_tuser    (tuser),
    .s_axi_tlast    (tlast),
    .gt_txdata_in   (a_data),
    .gt_txcharisk_in(a_k),
    .align_busy     (a_busy),
    .frame_done     (a_done)
  );

  gtx_tx_framer #(
    .LANES       (2),
    .ALIGN_PERIOD(Period),
    .ALIGN_WORD  (16'h4ABC),
    .ALIGN_K     (2'b01),
    .IDLE_WORD   (16'h957C),
    .IDLE_K      (2'b01)
  ) u_dut_b (
    .clk            (clk),
    .rst            (rst),
    .gtx_ready      (gtx_ready),
    .s_axi_tvalid   (tvalid),
    .s_axi_tready   (b_tready),
    .s_axi_tdata    (tdata[15:0]),
    .s_axi_tuser    (tuser[1:0]),
    .s_axi_tlast    (tlast),
    .gt_txdata_in   (b_data),
    .gt_txcharisk_in(b_k),
    .align_busy     (b_busy),
    .frame_done     (b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        tv;
    logic [31:0] d;
    logic [3:0]  u;
    logic        tl;
    logic        ex_tready;
    int          kind;
    logic [3:0]  ex_k;
    logic        ex_done;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rdy, input logic tv, input logic [31:0] d, input logic [3:0] u,
                     input logic tl, input logic ex_tready, input int kind,
                     input logic [3:0] ex_k, input logic ex_done);
    vec_t v;
    v.rdy = rdy; v.tv = tv; v.d = d; v.u = u; v.tl = tl;
    v.ex_tready = ex_tready; v.kind = kind; v.ex_k = ex_k; v.ex_done = ex_done;
    tbl.push_back(v);
  endtask

  // K mask of a data beat from the lane rules.
  function automatic logic [7:0] kmask(input logic [63:0] d, input logic [7:0] u, input int lanes);
    logic [7:0] k;
    k = '0;
    for (int i = 0; i < lanes; i++) begin
      k[i] = u[i];
      if (AutoK && d[8*i +: 8] == 8'hBC) k[i] = 1'b1;
    end
    return k;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_ready(input string tag, input logic exp);
    chk({tag, " a_tready"}, 64'(a_tready), 64'(exp));
    chk({tag, " b_tready"}, 64'(b_tready), 64'(exp));
  endtask

  // Compare both instances' registered outputs against the expected word kind.
  task automatic chk_out(input string tag, input int kind, input logic [31:0] d,
                         input logic [3:0] u, input logic [3:0] ka, input logic done);
    logic [31:0] ea;
    logic [3:0]  eka;
    logic [15:0] eb;
    logic [1:0]  ekb;
    logic [7:0]  kb;
    kb = kmask({48'b0, d[15:0]}, {6'b0, u[1:0]}, 2);
    case (kind)
      KAlign:  begin ea = 32'h7B4A4ABC; eka = 4'b0001; eb = 16'h4ABC; ekb = 2'b01; end
      KIdle:   begin ea = 32'hB5B5957C; eka = 4'b0001; eb = 16'h957C; ekb = 2'b01; end
      KData:   begin ea = d; eka = ka; eb = d[15:0]; ekb = kb[1:0]; end
      default: begin ea = '0; eka = '0; eb = '0; ekb = '0; end
    endcase
    chk({tag, " a_data"}, 64'(a_data), 64'(ea));
    chk({tag, " a_k"},    64'(a_k),    64'(eka));
    chk({tag, " a_busy"}, 64'(a_busy), 64'(kind == KAlign));
    chk({tag, " a_done"}, 64'(a_done), 64'(done));
    chk({tag, " b_data"}, 64'(b_data), 64'(eb));
    chk({tag, " b_k"},    64'(b_k),    64'(ekb));
    chk({tag, " b_busy"}, 64'(b_busy), 64'(kind == KAlign));
    chk({tag, " b_done"}, 64'(b_done), 64'(done));
  endtask

  initial begin
    int hk[4];
    logic hr[4];
    int p, p_next, m, kind;
    logic [7:0] kr;

    rst = 1'b1; gtx_ready = 1'b1; tvalid = 1'b0; tdata = '0; tuser = '0; tlast = 1'b0;

    // ---- directed table -------------------------------------------------
    add(1, 0, 32'h0,        4'h0,    0, 0, KZero,  4'h0, 0);  // OFF
    add(1, 1, 32'hDEADBEEF, 4'h0,    0, 0, KAlign, 4'h0, 0);  // ALIGN0, beat held
    add(1, 1, 32'hDEADBEEF, 4'h0,    0, 0, KAlign, 4'h0, 0);  // ALIGN1
    add(1, 0, 32'h0,        4'h0,    0, 1, KIdle,  4'h0, 0);  // RUN, idle fill
    add(1, 1, 32'h112233BC, 4'h0,    0, 1, KData,  AutoK ? 4'b0001 : 4'b0000, 0);
    add(1, 1, 32'h55667788, 4'b1000, 1, 1, KData,  4'b1000, 1);
    add(1, 1, 32'h112233BC, 4'b1000, 0, 1, KData,  AutoK ? 4'b1001 : 4'b1000, 0);
    add(0, 1, 32'h99999999, 4'h0,    0, 0, KZero,  4'h0, 0);  // link drop in RUN
    add(1, 0, 32'h0,        4'h0,    0, 0, KZero,  4'h0, 0);  // OFF -> ALIGN0
    add(0, 0, 32'h0,        4'h0,    0, 0, KZero,  4'h0, 0);  // drop during ALIGN0
    add(1, 0, 32'h0,        4'h0,    0, 0, KZero,  4'h0, 0);  // OFF -> ALIGN0
    add(1, 0, 32'h0,        4'h0,    0, 0, KAlign, 4'h0, 0);
    add(1, 0, 32'h0,        4'h0,    0, 0, KAlign, 4'h0, 0);
    for (int k = 0; k < 8; k++)
      add(1, 1, 32'h03020100 + 32'(k), 4'h0, k == 7, 1, KData, 4'h0, k == 7);
    add(1, 1, 32'hAAAAAAAA, 4'h0, 0, 0, KAlign, 4'h0, 0);     // exactly two stalls
    add(1, 1, 32'hAAAAAAAA, 4'h0, 0, 0, KAlign, 4'h0, 0);
    for (int k = 8; k < 12; k++)
      add(1, 1, 32'h03020100 + 32'(k), 4'h0, 0, 1, KData, 4'h0, 0);
    add(1, 0, 32'h0, 4'h0, 0, 1, KIdle, 4'h0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk_ready("reset", 1'b0);
    chk_out("reset", KZero, '0, '0, '0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      gtx_ready = tbl[i].rdy; tvalid = tbl[i].tv; tdata = tbl[i].d;
      tuser = tbl[i].u; tlast = tbl[i].tl;
      #1;
      chk_ready($sformatf("tbl%0d", i), tbl[i].ex_tready);
      @(posedge clk);
      #1;
      chk_out($sformatf("tbl%0d", i), tbl[i].kind, tbl[i].d, tbl[i].u, tbl[i].ex_k,
              tbl[i].ex_done);
    end

    // ---- reset in the middle of RUN, then link-up sequence -----------------
    rst = 1'b1; gtx_ready = 1'b1; tvalid = 1'b1; tdata = 32'h12345678; tuser = '0; tlast = 1'b1;
    @(posedge clk);
    #1;
    chk_ready("midrst", 1'b0);
    chk_out("midrst", KZero, '0, '0, '0, 1'b0);
    rst = 1'b0; tvalid = 1'b0; tlast = 1'b0;
    hk = '{KZero, KAlign, KAlign, KIdle};
    hr = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_ready($sformatf("relink%0d", i), hr[i]);
      @(posedge clk);
      #1;
      chk_out($sformatf("relink%0d", i), hk[i], '0, '0, '0, 1'b0);
    end

    // ---- randomized run against a positional model ----------------------
    // p counts cycles since the link came up (-1 = off). Output position
    // p mod (Period+2) is 0/1 for the ALIGN pair and RUN otherwise.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    p = -1;
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      gtx_ready = ($urandom_range(0, 59) != 0);
      tvalid    = ($urandom_range(0, 9) < 7);
      tdata     = $urandom;
      if ($urandom_range(0, 3) == 0) tdata[8*$urandom_range(0, 3) +: 8] = 8'hBC;
      tuser     = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      tlast     = ($urandom_range(0, 7) == 0);
      m = (p >= 0) ? (p % (Period + 2)) : 0;
      #1;
      chk_ready($sformatf("rnd%0d", c), (p >= 0) && (m >= 2) && gtx_ready && !rst);
      if (rst || !gtx_ready || p < 0) kind = KZero;
      else if (m < 2)                 kind = KAlign;
      else if (tvalid)                kind = KData;
      else                            kind = KIdle;
      p_next = (rst || !gtx_ready) ? -1 : p + 1;
      kr = kmask({32'b0, tdata}, {4'b0, tuser}, 4);
      @(posedge clk);
      #1;
      chk_out($sformatf("rnd%0d", c), kind, tdata, tuser, kr[3:0], (kind == KData) && tlast);
      p = p_next;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
